// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: recovers the displayed BCD digits from a multiplexed 4-digit
// 7-segment (FND) drive. The select and segment lines are registered once. A
// select must dwell with a stable select and font for SETTLE_CYC cycles before
// its digit is sampled. Each select dwell samples its digit once. When all four
// digits have been sampled, the frame is published on the next cycle.
//
// Parameters
//   SETTLE_CYC   stable cycles required before a digit is sampled (>= 1)
//   TIMEOUT_CYC  cycles without a completed frame before o_timeout rises
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   fnd_comm     digit select, active-low one-hot (4'b1110 = digit 0)
//   fnd_font     segment pattern, active-low, bit 7 = dp, bits 6:0 = g..a
//   o_digits     last complete frame, digit 3 in [15:12], digit 0 in [3:0]
//   o_dp         per-digit decimal point of the last frame, active-high
//   o_valid      one-cycle pulse when o_digits/o_dp update
//   o_font_err   some digit of the last frame had an undecodable pattern
//   o_timeout    no frame completed for TIMEOUT_CYC cycles
//   o_changed    (FND_SCAN_DECODER_CHANGE_EN only) pulses with o_valid when the
//                new frame differs from the previous one; the first frame after
//                reset always counts as changed
//
// Optional feature macro: FND_SCAN_DECODER_CHANGE_EN

module fnd_scan_decoder #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fnd_comm,
  input  logic [7:0]  fnd_font,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic        o_valid,
  output logic        o_font_err,
`ifdef FND_SCAN_DECODER_CHANGE_EN
  output logic        o_changed,
`endif
  output logic        o_timeout
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  // Select is valid only when exactly one line is driven low.
  function automatic logic sel_valid(input logic [3:0] comm);
    logic v;
    case (comm)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] comm);
    logic [1:0] idx;
    case (comm)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Returns {err, dp, nibble}. dp is taken from bit 7 even for bad patterns.
  function automatic logic [5:0] decode_font(input logic [7:0] font);
    logic [3:0] nib;
    logic       err;
    err = 1'b0;
    case (font[6:0])
      7'h40:   nib = 4'd0;
      7'h79:   nib = 4'd1;
      7'h24:   nib = 4'd2;
      7'h30:   nib = 4'd3;
      7'h19:   nib = 4'd4;
      7'h12:   nib = 4'd5;
      7'h02:   nib = 4'd6;
      7'h78:   nib = 4'd7;
      7'h00:   nib = 4'd8;
      7'h10:   nib = 4'd9;
      default: begin
        nib = 4'hF;
        err = 1'b1;
      end
    endcase
    return {err, ~font[7], nib};
  endfunction

  // Input registers and their one-cycle-delayed copies for change detection.
  logic [3:0]  comm_q, comm_p_q;
  logic [7:0]  font_q, font_p_q;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [15:0] shadow_digits_q, shadow_digits_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  mask_q, mask_d;

  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic        valid_q, valid_d;
  logic        font_err_q, font_err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic        comm_valid;
  logic        comm_chg;
  logic        font_chg;
  logic        sample;
  logic        done;
  logic [1:0]  sel_idx;
  logic [5:0]  dec;

  assign comm_valid = sel_valid(comm_q);
  assign comm_chg   = (comm_q != comm_p_q);
  assign font_chg   = (font_q != font_p_q);
  assign sel_idx    = sel_index(comm_q);
  assign dec        = decode_font(font_q);
  // A full mask publishes the frame on this edge and frees the shadow for reuse.
  assign done       = (mask_q == 4'hF);

  // Select FSM. The counter holds the number of consecutive stable cycles seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (comm_valid) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end
      end
      StSettle: begin
        if (!comm_valid) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (comm_chg || font_chg) begin
          cnt_d = CntW'(1);
        end else if (cnt_q >= CntW'(SETTLE_CYC - 1)) begin
          // This stable cycle brings the count to SETTLE_CYC.
          sample  = 1'b1;
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (comm_chg) begin
          if (comm_valid) begin
            state_d = StSettle;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow frame and published outputs.
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    // Clear on completion first so a sample on the same edge is kept.
    mask_d          = done ? 4'h0 : mask_q;
    err_d           = done ? 4'h0 : err_q;
    digits_d        = digits_q;
    dp_d            = dp_q;
    font_err_d      = font_err_q;
    valid_d         = done;

    if (sample) begin
      shadow_digits_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
      shadow_dp_d[sel_idx]                   = dec[4];
      err_d[sel_idx]                         = dec[5];
      mask_d[sel_idx]                        = 1'b1;
    end

    if (done) begin
      digits_d   = shadow_digits_q;
      dp_d       = shadow_dp_q;
      font_err_d = |err_q;
    end

    if (done) begin
      tmo_d = '0;
    end else if (tmo_q == TmoW'(TIMEOUT_CYC)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      comm_q          <= 4'hF;
      font_q          <= 8'hFF;
      comm_p_q        <= 4'hF;
      font_p_q        <= 8'hFF;
      state_q         <= StIdle;
      cnt_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      err_q           <= '0;
      mask_q          <= '0;
      digits_q        <= '0;
      dp_q            <= '0;
      valid_q         <= 1'b0;
      font_err_q      <= 1'b0;
      tmo_q           <= '0;
    end else begin
      comm_q          <= fnd_comm;
      font_q          <= fnd_font;
      comm_p_q        <= comm_q;
      font_p_q        <= font_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      err_q           <= err_d;
      mask_q          <= mask_d;
      digits_q        <= digits_d;
      dp_q            <= dp_d;
      valid_q         <= valid_d;
      font_err_q      <= font_err_d;
      tmo_q           <= tmo_d;
    end
  end

`ifdef FND_SCAN_DECODER_CHANGE_EN
  // first_q marks that no frame has been published since reset. The published
  // outputs themselves hold the previous frame for the compare.
  logic first_q;
  logic changed_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      first_q   <= 1'b1;
      changed_q <= 1'b0;
    end else begin
      changed_q <= done && (first_q || (shadow_digits_q != digits_q) || (shadow_dp_q != dp_q));
      if (done) begin
        first_q <= 1'b0;
      end
    end
  end

  assign o_changed = changed_q;
`endif

  assign o_digits   = digits_q;
  assign o_dp       = dp_q;
  assign o_valid    = valid_q;
  assign o_font_err = font_err_q;
  assign o_timeout  = (tmo_q == TmoW'(TIMEOUT_CYC));

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYC, default 4: number of cycles the digit select must be stable before the digit is sampled.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: number of cycles without a completed frame before a timeout is flagged.
REQ-003 clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 fnd_comm  input  4  digit select; active-low one-hot; 4'b1110 selects digit 0 and 4'b0111 selects digit 3.
REQ-006 fnd_font  input  8  segment pattern; active-low; bit 7 is dp, bits 6:0 are segments g..a.
REQ-007 o_digits  output  16  last complete frame as BCD nibbles; digit 3 is in bits 15:12 and digit 0 is in bits 3:0.
REQ-008 o_dp  output  4  dp state per digit from the last frame, active-high.
REQ-009 o_valid  output  1  one-cycle pulse when o_digits/o_dp update.
REQ-010 o_font_err  output  1  asserted with o_valid if any digit in that frame had an undecodable pattern; held until the next o_valid.
REQ-011 o_timeout  output  1  level; high while no frame has completed for TIMEOUT_CYC cycles.

Function
REQ-012 fnd_comm and fnd_font SHALL be registered once on input; all decode uses the registered copies.
REQ-013 The FSM SHALL have three states: IDLE, SETTLE, HOLD.
- IDLE: entered when comm is not exactly one-hot-low (for example 4'hF or 4'b1100).
- IDLE -> SETTLE: on a valid select; the stable counter is loaded with 1.
REQ-014 In SETTLE, the stable counter SHALL increment each cycle that comm and font both match the previous cycle.
- Any change restarts the count at 1.
- An invalid comm returns the FSM to IDLE.
REQ-015 When the stable count reaches SETTLE_CYC, the FSM SHALL sample that digit and move to HOLD; a digit is sampled exactly once per select dwell.
REQ-016 HOLD SHALL persist until comm changes.
- Changed to another valid select: go to SETTLE.
- Changed to an invalid select: go to IDLE.
REQ-017 Font decode (raw, active-low) to nibble:
- C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9.
- Bit 7 is ignored for the nibble and gives dp = ~bit7.
- Any other pattern decodes to nibble 4'hF and sets that digit's error bit.
REQ-018 Each sample SHALL write its digit's nibble, dp and error bit into a shadow frame and set its bit in a 4-bit captured mask.
- Re-sampling the same digit before the frame completes overwrites that digit's entry.
REQ-019 When the mask becomes 4'b1111, the following updates SHALL happen on the next cycle:
- o_digits and o_dp load from the shadow frame.
- o_font_err loads the OR of the error bits.
- o_valid pulses for one cycle.
- The mask and error bits clear.
REQ-020 If a sample completes the frame in the same cycle that a new select appears, the completion SHALL take effect and the new select SHALL enter SETTLE normally; no sample is lost.
REQ-021 Latency SHALL be 1 + SETTLE_CYC + 1 cycles from a stable select of the last digit to o_valid.
REQ-022 The timeout counter SHALL clear on o_valid and otherwise increment, saturating at TIMEOUT_CYC.
- o_timeout is high when the counter equals TIMEOUT_CYC.
- The next o_valid clears o_timeout in the same cycle it pulses.

Reset
REQ-023 While reset is low at a clk edge, the block SHALL clear the following:
- FSM goes to IDLE.
- Counters, mask, shadow frame and input registers clear; the input registers load comm 4'hF and font 8'hFF.
- o_digits 16'h0000, o_dp 4'h0, o_valid 0, o_font_err 0, o_timeout 0.
REQ-024 Reset mid-frame SHALL discard partially captured digits; the first o_valid after reset requires four fresh samples.

Configuration
REQ-025 Macro FND_SCAN_DECODER_CHANGE_EN, when defined, SHALL add output o_changed (1 bit).
- o_changed pulses with o_valid only if the new o_digits or o_dp differ from the previous frame.
- The first frame after reset counts as changed.
REQ-026 Without FND_SCAN_DECODER_CHANGE_EN, o_changed and its compare register SHALL not exist.

Verification (SETTLE_CYC=4, TIMEOUT_CYC=64 in bench)
REQ-027 Scan digits 0..3 with fonts C0, F9, A4, B0, 10 cycles each -> one o_valid after digit 3; o_digits=16'h3210, o_dp=0, o_font_err=0.
REQ-028 Digit 1 font 8'h79 (1 with dp lit) among C0/A4/B0 -> o_digits=16'h3210, o_dp=4'b0010.
REQ-029 Digit 2 font 8'hFF (blank) -> o_digits=16'h3F10, o_font_err=1; the next clean frame gives o_font_err=0.
REQ-030 Glitch: digit select held only 3 cycles, or font toggling every 2 cycles -> no sample, no o_valid; dwell for 4 stable cycles -> sample taken.
REQ-031 Stop scanning (comm=4'hF) -> o_timeout rises 64 cycles after the last o_valid; resumed scan -> o_timeout clears with the next o_valid.
REQ-032 Assert reset after 2 digits captured, then release and scan digits 2,3 only -> no o_valid until 0,1 are rescanned; with CHANGE_EN, two identical frames -> o_changed 1 then 0.
